// File: rtl/t_mod_counter_pkg.sv
// Shared constants, direction encoding and load clamp for the toggle-stage modulo counter.
package t_count_pkg;

    localparam int unsigned T_WIDTH_DEF   = 4;
    localparam int unsigned T_MODULUS_DEF = 10;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Out-of-range load values saturate to the top count so q never leaves 0..N-1.
    function automatic int unsigned clamp_load(input int unsigned value, input int unsigned modulus);
        return (value < modulus) ? value : (modulus - 1);
    endfunction

endpackage

// File: rtl/t_mod_counter_if.sv
// Control/status bundle between a counter user (master) and t_mod_counter (slave).
// The dir signal exists only when T_MOD_COUNTER_DOWN_EN is defined.
interface t_mod_counter_if import t_count_pkg::*; #(
    parameter int unsigned WIDTH = T_WIDTH_DEF
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
`ifdef T_MOD_COUNTER_DOWN_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
`ifdef T_MOD_COUNTER_DOWN_EN
        output dir,
`endif
        output en, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
`ifdef T_MOD_COUNTER_DOWN_EN
        input  dir,
`endif
        input  en, load, load_val,
        output q, tc, wrap
    );
endinterface

// File: rtl/t_mod_counter_stage.sv
// Single toggle flip-flop: q flips when t is high; synchronous active-low reset.
module t_stage (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk) begin
        if (!reset) q <= 1'b0;
        else        q <= q ^ t;
    end
endmodule

// File: rtl/t_mod_counter.sv
// Modulo-N counter built from T stages: toggle-equation logic, tc decode and registered wrap pulse.
// Up/down counting is built only when T_MOD_COUNTER_DOWN_EN is defined; otherwise up-only.
module t_mod_counter import t_count_pkg::*; #(
    parameter int unsigned WIDTH   = T_WIDTH_DEF,
    parameter int unsigned MODULUS = T_MODULUS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    t_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] load_l;
    logic             up_term;
    logic             term;
    logic             wrap_q;

    assign load_l  = WIDTH'(clamp_load(32'(bus.load_val), MODULUS));
    assign up_term = (q == MAX);

    always_comb begin
        up_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) up_t[i] = up_t[i-1] & q[i-1];
    end

`ifdef T_MOD_COUNTER_DOWN_EN
    logic [WIDTH-1:0] dn_t;
    logic             dn_term;
    logic             count_up;

    assign dn_term  = (q == '0);
    assign count_up = (bus.dir == DIR_UP);
    assign term     = count_up ? up_term : dn_term;

    // Down-count borrow chain: a bit toggles when every lower bit is zero.
    always_comb begin
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) dn_t[i] = dn_t[i-1] & ~q[i-1];
    end

    always_comb begin
        t = '0;
        if (bus.load)       t = q ^ load_l;
        else if (bus.en) begin
            if (count_up)   t = up_term ? q : up_t;
            else            t = dn_term ? (q ^ MAX) : dn_t;
        end
    end
`else
    assign term = up_term;

    always_comb begin
        t = '0;
        if (bus.load)       t = q ^ load_l;
        else if (bus.en)    t = up_term ? q : up_t;
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        t_stage u_stage (
            .clk   (clk),
            .reset (reset),
            .t     (t[i]),
            .q     (q[i])
        );
    end

    // Load has priority over counting, so a terminal count during load never wraps.
    always_ff @(posedge clk) begin
        if (!reset) wrap_q <= 1'b0;
        else        wrap_q <= ~bus.load & bus.en & term;
    end

    assign bus.q    = q;
    assign bus.tc   = bus.en & term;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_t_mod_counter.sv
// Randomized and directed checks of t_mod_counter against an arithmetic modulo-N reference model.
module tb_t_mod_counter;
    import t_count_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned N = 10;

    logic clk = 1'b0;
    logic reset;
    logic dir_s;
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model state
    int   m_q    = 0;
    int   m_wrap = 0;

    always #5 clk = ~clk;

    t_mod_counter_if #(.WIDTH(W)) bus ();

`ifdef T_MOD_COUNTER_DOWN_EN
    assign bus.dir = dir_s;
`endif

    t_mod_counter #(.WIDTH(W), .MODULUS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit dir_up(input logic d);
`ifdef T_MOD_COUNTER_DOWN_EN
        return d == DIR_UP;
`else
        return 1'b1;
`endif
    endfunction

    // One cycle: apply inputs after the falling edge, check outputs, then advance the model at the rising edge.
    task automatic step(input logic r, input logic e, input logic l, input int lv, input logic d);
        int exp_tc;
        @(negedge clk);
        reset        = r;
        bus.en       = e;
        bus.load     = l;
        bus.load_val = W'(lv);
        dir_s        = d;
        #1;
        exp_tc = (e && (dir_up(d) ? (m_q == N - 1) : (m_q == 0))) ? 1 : 0;
        chk("q",    int'(bus.q),    m_q);
        chk("wrap", int'(bus.wrap), m_wrap);
        chk("tc",   int'(bus.tc),   exp_tc);
        @(posedge clk);
        if (!r) begin
            m_q = 0; m_wrap = 0;
        end else if (l) begin
            m_q = (lv < N) ? lv : N - 1; m_wrap = 0;
        end else if (e) begin
            if (dir_up(d)) begin
                m_wrap = (m_q == N - 1); m_q = (m_q + 1) % N;
            end else begin
                m_wrap = (m_q == 0);     m_q = (m_q + N - 1) % N;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    int wraps;

    initial begin
        reset = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0; dir_s = 1'b1;

        // reset dominates load and enable
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 5, 1'b1);
        step(1'b1, 1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        chk("first_count", int'(bus.q), 1);

        // up wrap from zero
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 0, 1'b1);
            wraps += int'(bus.wrap);
        end
        chk("wrap_count", wraps, 1);

        // load clamp, then load wins over enable
        step(1'b1, 1'b0, 1'b1, 13, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        chk("load_no_inc", int'(bus.q), 4);

        // hold at 6
        step(1'b1, 1'b0, 1'b1, 6, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        chk("hold", int'(bus.q), 6);

        // load while at terminal count: no wrap follows
        step(1'b1, 1'b0, 1'b1, 9, 1'b1);
        step(1'b1, 1'b1, 1'b1, 3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);

`ifdef T_MOD_COUNTER_DOWN_EN
        // down through zero, then reverse at 8
        step(1'b1, 1'b0, 1'b1, 2, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);
        chk("dir_flip", int'(bus.q), 9);
`endif

        // reset on the wrapping edge suppresses the pulse
        step(1'b1, 1'b0, 1'b1, 9, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) >= 3),
                 ($urandom_range(0, 99) < 75),
                 ($urandom_range(0, 99) < 8),
                 int'($urandom_range(0, (1 << W) - 1)),
                 (($urandom_range(0, 99) < 80) ? dir_s : 1'($urandom)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
